// File: rtl/mem_req_tracker_pkg.sv
// mem_req_tracker_pkg
//   Shared defaults and width derivations for the memory request tracker
//   and its tag FIFO.
//   DEFAULT_MAX_OUT : default number of outstanding requests.
//   DEFAULT_TAG_W   : default width of the per-request tag.
//   cnt_width()     : width needed to hold a count 0..max_out.
//   ptr_width()     : width needed to index depth entries (at least 1).
package mem_req_tracker_pkg;

    localparam int DEFAULT_MAX_OUT = 2;
    localparam int DEFAULT_TAG_W   = 8;

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_req_tracker_tag_fifo.sv
// req_tag_fifo
//   In-order tag store for in-flight memory requests. The depth does not
//   need to be a power of two: both pointers wrap explicitly from DEPTH-1
//   back to 0. The head entry is read combinationally so a response can be
//   tagged in the same cycle it arrives. Full/empty tracking lives in the
//   parent, which never pushes when full or pops when empty.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset (pointers only)
//   push        : write push_tag at the tail
//   push_tag    : tag to store
//   pop         : advance the head
//   head        : tag at the head (oldest entry)
module req_tag_fifo
    import mem_req_tracker_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_OUT,
    parameter int TAG_W = DEFAULT_TAG_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head
);

    localparam int             PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read
    // after it has been written, so clearing it would add nothing.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_tag;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mem_req_tracker.sv
// mem_req_tracker
//   Tracks in-order memory requests: gates the pipeline's request on a free
//   slot, stores each accepted request's tag, and returns the oldest tag
//   with zero latency when the memory signals a response. An unexpected
//   response (nothing in flight) raises a sticky protocol error.
//   Optional flush: define MEM_REQ_TRACKER_CANCEL_EN to make cancel block
//   the current request and silently drain every response still in flight.
//   Without the macro the cancel port is present but ignored.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   req/req_tag : pipeline request and its tag
//   addr_ok     : memory accepts the address this cycle
//   data_ok     : memory returns one response this cycle
//   cancel      : flush pulse (only with MEM_REQ_TRACKER_CANCEL_EN)
//   mem_req     : gated request to memory
//   can_issue   : a slot is free (registered state only)
//   rsp_valid   : response delivered, rsp_tag is its tag
//   outstanding : requests in flight
//   proto_err   : sticky, data_ok seen with nothing in flight
module mem_req_tracker
    import mem_req_tracker_pkg::*;
#(
    parameter  int MAX_OUT = DEFAULT_MAX_OUT,
    parameter  int TAG_W   = DEFAULT_TAG_W,
    localparam int CNT_W   = cnt_width(MAX_OUT)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             addr_ok,
    input  logic             data_ok,
    input  logic             cancel,
    output logic             mem_req,
    output logic             can_issue,
    output logic             rsp_valid,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] outstanding,
    output logic             proto_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] out_cnt;
    logic             cancel_active;
    logic             discarding;
    logic             handshake;
    logic             accept;

    // can_issue looks only at the registered count, so a response arriving
    // while full frees the slot from the following cycle.
    assign can_issue = (out_cnt < MAX_CNT);
    assign mem_req   = req & can_issue & ~cancel_active;
    assign handshake = mem_req & addr_ok;
    assign accept    = data_ok & (out_cnt != '0);
    assign rsp_valid = accept & ~discarding;
    assign outstanding = out_cnt;

`ifdef MEM_REQ_TRACKER_CANCEL_EN
    logic [CNT_W-1:0] discard_cnt;

    assign cancel_active = cancel;
    assign discarding    = (discard_cnt != '0);

    // A cancel captures what will still be in flight after this cycle's
    // pop; no push can happen that cycle because mem_req is blocked.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt <= '0;
        end else if (cancel) begin
            discard_cnt <= out_cnt - CNT_W'(accept);
        end else if (accept && discarding) begin
            discard_cnt <= discard_cnt - CNT_W'(1);
        end
    end
`else
    logic unused_cancel;

    assign cancel_active = 1'b0;
    assign discarding    = 1'b0;
    assign unused_cancel = cancel;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_cnt <= '0;
        end else if (handshake && !accept) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end else if (accept && !handshake) begin
            out_cnt <= out_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            proto_err <= 1'b0;
        end else if (data_ok && (out_cnt == '0)) begin
            proto_err <= 1'b1;
        end
    end

    req_tag_fifo #(
        .DEPTH (MAX_OUT),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (handshake),
        .push_tag (req_tag),
        .pop      (accept),
        .head     (rsp_tag)
    );

endmodule

// File: tb/tb_mem_req_tracker.sv
// tb_mem_req_tracker
//   Two instances: a MAX_OUT=2 tracker driven by directed sequences, and a
//   MAX_OUT=3 tracker driven by random stimulus against a queue-based
//   reference model. Expected responses are queued when data_ok is issued;
//   a monitor pops and compares whenever the DUT raises rsp_valid.
module tb_mem_req_tracker;
    import mem_req_tracker_pkg::*;

`ifdef MEM_REQ_TRACKER_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif
    localparam int M3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // MAX_OUT = 2 instance (directed)
    logic       resetn2, req2, addr2, data2, cancel2;
    logic [7:0] tag2;
    logic       mem_req2, can2, rv2, perr2;
    logic [7:0] rtag2;
    logic [cnt_width(2)-1:0] out2;

    // MAX_OUT = 3 instance (random)
    logic       resetn3, req3, addr3, data3, cancel3;
    logic [7:0] tag3;
    logic       mem_req3, can3, rv3, perr3;
    logic [7:0] rtag3;
    logic [cnt_width(M3)-1:0] out3;

    mem_req_tracker #(.MAX_OUT(2), .TAG_W(8)) u_dut2 (
        .clk(clk), .resetn(resetn2), .req(req2), .req_tag(tag2),
        .addr_ok(addr2), .data_ok(data2), .cancel(cancel2),
        .mem_req(mem_req2), .can_issue(can2), .rsp_valid(rv2),
        .rsp_tag(rtag2), .outstanding(out2), .proto_err(perr2)
    );

    mem_req_tracker #(.MAX_OUT(M3), .TAG_W(8)) u_dut3 (
        .clk(clk), .resetn(resetn3), .req(req3), .req_tag(tag3),
        .addr_ok(addr3), .data_ok(data3), .cancel(cancel3),
        .mem_req(mem_req3), .can_issue(can3), .rsp_valid(rv3),
        .rsp_tag(rtag3), .outstanding(out3), .proto_err(perr3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed driver for the MAX_OUT=2 instance ----------
    // Inputs change 1 time unit after the edge; checks follow 1 unit later.
    task automatic d2_drive(input logic r, input logic [7:0] t, input logic a,
                            input logic d, input logic c);
        @(posedge clk);
        #1;
        req2 = r; tag2 = t; addr2 = a; data2 = d; cancel2 = c;
        #1;
    endtask

    task automatic d2_reset();
        @(posedge clk);
        #1;
        req2 = 0; tag2 = 0; addr2 = 0; data2 = 0; cancel2 = 0;
        resetn2 = 0;
        #1;
        check("d2_reset_out", out2, 0);
        check("d2_reset_perr", perr2, 0);
        @(posedge clk);
        #1;
        resetn2 = 1;
    endtask

    // ---------------- reference model + scoreboard for MAX_OUT=3 ----------
    logic [7:0] m_inflight[$];  // tags in flight, oldest first
    int         m_discard = 0;  // responses still to be swallowed
    bit         m_perr    = 0;
    logic [7:0] exp_q[$];       // responses the pipeline should see

    task automatic d3_cycle(input logic r, input logic [7:0] t, input logic a,
                            input logic d, input logic c);
        bit         cancel_act;
        bit         exp_mr;
        bit         hs;
        logic [7:0] front;
        @(posedge clk);
        #1;
        req3 = r; tag3 = t; addr3 = a; data3 = d; cancel3 = c;
        #1;
        cancel_act = CANCEL_EN && c;
        exp_mr     = r && (m_inflight.size() < M3) && !cancel_act;
        check("d3_can_issue", can3, (m_inflight.size() < M3));
        check("d3_mem_req", mem_req3, exp_mr);
        check("d3_outstanding", out3, m_inflight.size());
        check("d3_proto_err", perr3, m_perr);
        hs = exp_mr && a;
        if (d) begin
            if (m_inflight.size() == 0) begin
                m_perr = 1;
            end else begin
                front = m_inflight.pop_front();
                if (m_discard > 0) m_discard--;
                else exp_q.push_back(front);
            end
        end
        if (cancel_act) m_discard = m_inflight.size();
        if (hs) m_inflight.push_back(t);
    endtask

    task automatic d3_reset();
        @(posedge clk);
        #1;
        req3 = 0; tag3 = 0; addr3 = 0; data3 = 0; cancel3 = 0;
        resetn3 = 0;
        #1;
        check("d3_reset_out", out3, 0);
        check("d3_reset_perr", perr3, 0);
        check("d3_reset_can", can3, 1);
        m_inflight.delete();
        m_discard = 0;
        m_perr    = 0;
        @(posedge clk);
        #1;
        resetn3 = 1;
    endtask

    // Monitor: every delivered response must match the oldest expected one.
    always @(negedge clk) begin
        if (resetn3 && rv3) begin
            if (exp_q.size() == 0) begin
                check("d3_rsp_unexpected", 1, 0);
            end else begin
                check("d3_rsp_tag", rtag3, exp_q.pop_front());
            end
        end
    end

    initial begin
        resetn2 = 0; req2 = 1; tag2 = 0; addr2 = 0; data2 = 0; cancel2 = 0;
        resetn3 = 0; req3 = 0; tag3 = 0; addr3 = 0; data3 = 0; cancel3 = 0;
        #3;
        check("rst_out", out2, 0);
        check("rst_can_issue", can2, 1);
        check("rst_rsp_valid", rv2, 0);
        check("rst_proto_err", perr2, 0);
        check("rst_mem_req_follows_req", mem_req2, 1);
        #9;
        resetn2 = 1;
        resetn3 = 1;

        // Fill to MAX_OUT=2, then drain in order.
        d2_drive(1, 8'h11, 1, 0, 0);
        check("fill_mem_req0", mem_req2, 1);
        d2_drive(1, 8'h22, 1, 0, 0);
        check("fill_out1", out2, 1);
        d2_drive(1, 8'h33, 1, 0, 0);
        check("full_out", out2, 2);
        check("full_can_issue", can2, 0);
        check("full_mem_req", mem_req2, 0);
        d2_drive(0, 0, 0, 1, 0);
        check("drain0_valid", rv2, 1);
        check("drain0_tag", rtag2, 8'h11);
        check("drain0_can_issue_same_cycle", can2, 0);
        d2_drive(0, 0, 0, 1, 0);
        check("drain1_valid", rv2, 1);
        check("drain1_tag", rtag2, 8'h22);
        check("drain1_out", out2, 1);
        d2_drive(0, 0, 0, 0, 0);
        check("drained_out", out2, 0);

        // Simultaneous push and pop at outstanding=1.
        d2_drive(1, 8'h44, 1, 0, 0);
        d2_drive(1, 8'h55, 1, 1, 0);
        check("simul_mem_req", mem_req2, 1);
        check("simul_valid", rv2, 1);
        check("simul_tag", rtag2, 8'h44);
        d2_drive(0, 0, 0, 0, 0);
        check("simul_out", out2, 1);
        check("simul_new_head", rtag2, 8'h55);
        d2_drive(0, 0, 0, 1, 0);
        check("simul_pop2_tag", rtag2, 8'h55);
        d2_drive(0, 0, 0, 0, 0);
        check("simul_out_end", out2, 0);

        // Unexpected data_ok.
        d2_drive(0, 0, 0, 1, 0);
        check("perr_rsp_valid", rv2, 0);
        d2_drive(0, 0, 0, 0, 0);
        check("perr_set", perr2, 1);
        check("perr_out", out2, 0);
        d2_drive(1, 8'h5a, 1, 0, 0);
        d2_drive(0, 0, 0, 1, 0);
        check("perr_sticky", perr2, 1);
        d2_reset();

        // Asynchronous reset with two in flight.
        d2_drive(1, 8'h66, 1, 0, 0);
        d2_drive(1, 8'h77, 1, 0, 0);
        d2_drive(1, 8'h88, 0, 1, 0);
        check("areset_pre_out", out2, 2);
        check("areset_pre_tag", rtag2, 8'h66);
        #2;
        resetn2 = 0;
        #1;
        check("areset_out", out2, 0);
        check("areset_can_issue", can2, 1);
        check("areset_rsp_valid", rv2, 0);
        check("areset_mem_req", mem_req2, 1);
        req2 = 0;
        #2;
        resetn2 = 1;
        #1;
        check("post_reset_rsp_valid", rv2, 0);
        @(posedge clk);
        #1;
        check("post_reset_perr", perr2, 1);
        check("post_reset_out", out2, 0);
        d2_reset();

`ifdef MEM_REQ_TRACKER_CANCEL_EN
        d2_drive(1, 8'h81, 1, 0, 0);
        d2_drive(1, 8'h82, 1, 0, 0);
        d2_drive(1, 8'h83, 1, 0, 1);
        check("cancel_mem_req", mem_req2, 0);
        d2_drive(0, 0, 0, 1, 0);
        check("discard0_valid", rv2, 0);
        check("discard0_out", out2, 2);
        d2_drive(0, 0, 0, 1, 0);
        check("discard1_valid", rv2, 0);
        check("discard1_out", out2, 1);
        d2_drive(1, 8'h84, 1, 0, 0);
        check("after_cancel_out", out2, 0);
        check("after_cancel_mem_req", mem_req2, 1);
        d2_drive(0, 0, 0, 1, 0);
        check("after_cancel_valid", rv2, 1);
        check("after_cancel_tag", rtag2, 8'h84);
        d2_drive(0, 0, 0, 0, 0);
        check("after_cancel_end", out2, 0);
`else
        d2_drive(1, 8'h91, 1, 0, 1);
        check("cancel_ignored_mem_req", mem_req2, 1);
        d2_drive(0, 0, 0, 1, 0);
        check("cancel_ignored_valid", rv2, 1);
        check("cancel_ignored_tag", rtag2, 8'h91);
        d2_drive(0, 0, 0, 0, 0);
`endif

        // MAX_OUT=3: seven issue/response pairs wrap both pointers.
        d3_reset();
        for (int i = 0; i < 7; i++) begin
            d3_cycle(1, 8'(8'hA0 + i), 1, 0, 0);
            d3_cycle(0, 0, 0, 1, 0);
        end

        // Random traffic, with a reset every 500 cycles.
        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 499) begin
                d3_reset();
            end else begin
                d3_cycle(($urandom_range(0, 9) < 7), 8'($urandom),
                         ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
                         ($urandom_range(0, 19) == 0));
            end
        end
        d3_cycle(0, 0, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_tracker.md
MEM_REQ_TRACKER -- requirements
Module: mem_req_tracker

Interface
REQ-001 The block SHALL have the parameter MAX_OUT, default 2, giving the maximum number of outstanding requests (legal range 1..8; need not be a power of two).
REQ-002 The block SHALL have the parameter TAG_W, default 8, giving the width of the per-request tag returned with each response.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  clock; all state is updated on its rising edge.
REQ-005 Port: resetn  input  1  asynchronous active-low reset.
REQ-006 Port: req  input  1  pipeline wants to issue a memory request this cycle.
REQ-007 Port: req_tag  input  TAG_W  tag attached to the request (load type, destination register, etc.).
REQ-008 Port: addr_ok  input  1  memory accepts the address this cycle.
REQ-009 Port: data_ok  input  1  memory returns one response this cycle, in order.
REQ-010 Port: cancel  input  1  flush pulse; all in-flight responses are to be discarded.
REQ-011 Port: mem_req  output  1  gated request to memory.
REQ-012 Port: can_issue  output  1  tracker has a free slot.
REQ-013 Port: rsp_valid  output  1  response delivered to the pipeline.
REQ-014 Port: rsp_tag  output  TAG_W  tag of the delivered response.
REQ-015 Port: outstanding  output  CNT_W  live count of requests in flight; CNT_W = clog2(MAX_OUT+1).
REQ-016 Port: proto_err  output  1  sticky flag for an unexpected data_ok.

Function
REQ-017 can_issue SHALL equal (outstanding < MAX_OUT) and SHALL be computed from registered state only, with no combinational path from data_ok or addr_ok.
REQ-018 mem_req SHALL equal req & can_issue & ~cancel_active, where cancel_active is cancel when CANCEL_EN is defined and 0 otherwise.
REQ-019 An address handshake SHALL occur when mem_req & addr_ok; on a handshake req_tag is pushed into the tag FIFO and outstanding increments at the next edge.
REQ-020 A response SHALL be accepted when data_ok & (outstanding != 0); on acceptance the FIFO head is popped and outstanding decrements.
REQ-021 rsp_valid SHALL equal accepted-response & ~discarding, and rsp_tag SHALL equal the FIFO head combinationally, giving zero-cycle latency from data_ok.
REQ-022 When a handshake and an accepted response occur in the same cycle, outstanding SHALL be unchanged and both the push and the pop SHALL take effect.
REQ-023 The write and read pointers SHALL wrap from MAX_OUT-1 to 0.
REQ-024 Responses SHALL be strictly in order; tags are returned in push order.
REQ-025 When outstanding == 0, data_ok SHALL NOT pop or change outstanding, SHALL keep rsp_valid = 0, and SHALL set proto_err, which holds until reset.
REQ-026 When outstanding == MAX_OUT, can_issue = 0 and mem_req = 0; a same-cycle data_ok frees the slot only from the next cycle.

Reset
REQ-027 While resetn = 0, the following SHALL be cleared: outstanding = 0, pointers = 0, discard count = 0, proto_err = 0; hence can_issue = 1, rsp_valid = 0, and mem_req follows req.
REQ-028 A reset in mid-operation SHALL drop all in-flight tracking; any data_ok arriving later with outstanding == 0 SHALL set proto_err per REQ-025.

Configuration
REQ-029 The macro MEM_REQ_TRACKER_CANCEL_EN SHALL control the flush feature.
REQ-030 With MEM_REQ_TRACKER_CANCEL_EN defined, a cancel pulse SHALL:
- load discard_cnt with the outstanding count remaining after any same-cycle pop;
- block mem_req in that cycle.
REQ-031 While discard_cnt > 0, each accepted response SHALL pop the FIFO, decrement outstanding and discard_cnt, and keep rsp_valid = 0 ("discarding").
REQ-032 Without MEM_REQ_TRACKER_CANCEL_EN, the cancel port SHALL exist but be ignored, and discard_cnt SHALL be absent (discarding = 0).

Structure
REQ-033 The shared package/header SHALL hold the default values of MAX_OUT and TAG_W and the CNT_W/pointer-width derivation.
REQ-034 The tag storage SHALL be a single sub-module, req_tag_fifo: depth MAX_OUT, non-power-of-two wrap, combinational head read.
REQ-035 Counter, discard logic and handshake gating SHALL stay in mem_req_tracker.

Verification
REQ-036 MAX_OUT=2: issue tags 0x11, 0x22 (addr_ok=1 each).
- outstanding=2, can_issue=0, mem_req=0 while req=1.
- data_ok twice -> rsp_tag 0x11 then 0x22, outstanding returns to 0.
REQ-037 MAX_OUT=3: run 7 issue/response pairs -> pointers wrap and tags return in order with no loss.
REQ-038 outstanding=1 with handshake and data_ok in the same cycle -> outstanding stays 1, popped tag delivered, new tag becomes head.
REQ-039 data_ok with outstanding=0 -> rsp_valid=0, outstanding=0, proto_err=1 until resetn low.
REQ-040 CANCEL_EN, 2 outstanding, cancel pulse with req=1:
- mem_req=0 that cycle.
- Next two data_ok -> rsp_valid=0, outstanding 2->1->0.
- Third request after that -> normal response.
REQ-041 resetn asserted with outstanding=2 -> outputs go to reset values asynchronously, before the next clk edge.
